control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the Phase-1 datapath's control inputs, replacing hand-written per-instruction state sequences in benches.
- Runs fetch (T0–T2) and then an opcode-dependent execute sequence (T3–T6), using the IR contents fed back from the datapath.
- Sits beside `datapath`. Its outputs wire one-to-one onto the datapath control pins: the rin/rout vectors fan out to R0in..R15in and R0out..R15out.

Parameters:
- MEM_TIMEOUT, 16: maximum T1 cycles spent waiting for mem_ready before a fault is raised (range 1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock, in, 1: system clock; all state changes on its rising edge.
- clear, in, 1: synchronous active-high reset.
- run, in, 1: permission to start the next instruction.
- mem_ready, in, 1: memory read data is valid this cycle.
- ir, in, 32: current IR value from the datapath.
- rin, out, 16: one-hot register-load enables; bit n = Rn_in.
- rout, out, 16: one-hot register bus drivers; bit n = Rn_out.
- pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in, y_in, z_in, hi_in, lo_in, zlow_out, zhigh_out: out, 1 each; datapath strobes.
- alu_ctrl, out, 5: ALU operation select.
- halted, out, 1: high while in HALT.
- fault, out, 1: sticky; set on illegal opcode or memory timeout.
- instr_count, out, CNT_W: count of retired instructions.
- state_dbg, out, 4: current state encoding.

Behaviour:
- Clock and reset: one clock (`clock`); reset is synchronous, active-high (`clear`).
- Reset response: clear wins over every other input. On clear the state becomes IDLE, every strobe, rin, rout and alu_ctrl is 0, and halted, fault and instr_count are 0.
- Output style: strobes are Moore-decoded from the state plus the IR fields; no registered output lag. At most one rout bit or *_out strobe is high in any cycle.
- IR fields: op = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
- IDLE: all strobes 0. Goes to T0 when run=1.
- T0: pc_out, mar_in, inc_pc, z_in.
- T1 (read wait):
  - Asserts zlow_out, pc_in, read, mdr_in every cycle it is held; repeated pc_in is idempotent.
  - Moves to T2 when mem_ready=1.
  - A wait counter counts cycles in T1. If it reaches MEM_TIMEOUT with mem_ready=0, set fault and go to HALT.
  - If mem_ready rises on the same cycle the counter reaches the limit, mem_ready wins.
- T2: mdr_out, ir_in. IR becomes valid from T3 onward.
- T3 by opcode class:
  - 3-register ALU ops (ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL):
    - T3: rout[rb], y_in.
    - T4: rout[rc], alu_ctrl=op, z_in.
    - T5: zlow_out, rin[ra]. Then to END.
  - Unary ops (NEG, NOT):
    - T3: rout[rb], alu_ctrl=op, z_in.
    - T4: zlow_out, rin[ra]. Then to END.
  - MUL, DIV:
    - T3: rout[ra], y_in.
    - T4: rout[rb], alu_ctrl=op, z_in.
    - T5: zlow_out, lo_in.
    - T6: zhigh_out, hi_in. Then to END.
  - NOP: straight to END.
  - HALT: to the HALT state; the instruction is not counted.
  - Any other opcode: set fault, go to HALT.
- END (not a state): increment instr_count, wrapping modulo 2^CNT_W. Next state is T0 if run=1, otherwise IDLE.
- alu_ctrl: equals op only in cycles that assert z_in during execute. In T0 it is 0; the datapath increments the PC through inc_pc.
- HALT: halted=1, all strobes 0. Only clear leaves it.
- run: sampled only at IDLE and at END. Dropping run mid-instruction does not abort the instruction.
- clear mid-instruction: abandons the sequence immediately. Partial register writes already clocked remain in the datapath.
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011.

Decomposition:
- Shared include `ctrl_defs.vh` holds:
  - the opcode constants;
  - the state encodings: IDLE 0, T0 1, T1 2, T2 3, T3 4, T4 5, T5 6, T6 7, HALT 8;
  - the opcode-class codes ALU3, UNARY, MULDIV, NOP, HALT, ILLEGAL.
- One sub-module, `ir_decoder`: combinational. Takes ir and produces op class, alu_ctrl, and one-hot decodes of ra, rb, rc.
- The FSM, wait counter and instr_count stay in `control_sequencer`.

Test Plan:
- clear=1 for 2 cycles then run=1, mem_ready tied 1 → IDLE, T0, T1, T2 on consecutive cycles; T0 shows pc_out=mar_in=inc_pc=z_in=1; all outputs 0 during clear.
- ADD with ir=0x19A20000 (op 00011, ra=3, rb=4, rc=4) → T3 rout=0x0010 with y_in; T4 rout=0x0010 with alu_ctrl=00011 and z_in; T5 rin=0x0008 with zlow_out; instr_count becomes 1.
- NEG with ir=0x8A380000 (op 10001, ra=4, rb=7) → T3 rout=0x0080, alu_ctrl=10001, z_in; T4 rin=0x0010, zlow_out; the next state is T0.
- MUL → T5 has lo_in with zlow_out; T6 has hi_in with zhigh_out; 7 cycles from T0 to the next T0.
- mem_ready held low 16 cycles (MEM_TIMEOUT=16) → fault=1, halted=1, instr_count unchanged. Separately, mem_ready asserted on cycle 16 → proceeds to T2, fault=0.
- Opcode 11111 → fault=1 and HALT. HALT opcode 11011 → halted=1, fault=0, count unchanged. clear in either case → IDLE with all outputs 0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: state and opcode-class
// encodings, opcode constants and a register-select one-hot helper.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU3    = 3'd0,
        CLS_UNARY   = 3'd1,
        CLS_MULDIV  = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_ir_decoder.sv
// Combinational IR field decoder: opcode class, ALU select and one-hot register
// selects for the ra/rb/rc fields (ir[31:15]; the low bits carry no control info).
module ir_decoder
    import control_sequencer_pkg::*;
(
    input  logic [31:15] ir,
    output op_class_t    op_class,
    output logic [4:0]   alu_op,
    output logic [15:0]  ra_oh,
    output logic [15:0]  rb_oh,
    output logic [15:0]  rc_oh
);

    logic [4:0] op_s;

    assign op_s  = ir[31:27];
    assign ra_oh = onehot16(ir[26:23]);
    assign rb_oh = onehot16(ir[22:19]);
    assign rc_oh = onehot16(ir[18:15]);

    // Classify the opcode; only ALU-using classes pass op through to the ALU select.
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = 5'd0;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                op_class = CLS_ALU3;
                alu_op   = op_s;
            end
            OP_NEG, OP_NOT: begin
                op_class = CLS_UNARY;
                alu_op   = op_s;
            end
            OP_MUL, OP_DIV: begin
                op_class = CLS_MULDIV;
                alu_op   = op_s;
            end
            OP_NOP:  op_class = CLS_NOP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then opcode-dependent execute (T3-T6),
// with Moore-decoded datapath strobes, a T1 read-wait timeout and a retire counter.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic [15:0]      rin,
    output logic [15:0]      rout,
    output logic             pc_out,
    output logic             pc_in,
    output logic             inc_pc,
    output logic             mar_in,
    output logic             mdr_in,
    output logic             mdr_out,
    output logic             read,
    output logic             ir_in,
    output logic             y_in,
    output logic             z_in,
    output logic             hi_in,
    output logic             lo_in,
    output logic             zlow_out,
    output logic             zhigh_out,
    output logic [4:0]       alu_ctrl,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t          state_r, next_state_s;
    logic [7:0]      wait_cnt_r;
    logic            fault_r;
    logic [CNT_W-1:0] count_r;
    logic            retire_s, set_fault_s;

    op_class_t       op_class_s;
    logic [4:0]      alu_op_s;
    logic [15:0]     ra_oh_s, rb_oh_s, rc_oh_s;

    ir_decoder u_ir_decoder (
        .ir       (ir[31:15]),
        .op_class (op_class_s),
        .alu_op   (alu_op_s),
        .ra_oh    (ra_oh_s),
        .rb_oh    (rb_oh_s),
        .rc_oh    (rc_oh_s)
    );

    assign fault       = fault_r;
    assign instr_count = count_r;
    assign state_dbg   = state_r;

    // State register, T1 wait counter, sticky fault and retired-instruction count.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 8'd0;
            fault_r    <= 1'b0;
            count_r    <= '0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= (state_r == ST_T1) ? wait_cnt_r + 8'd1 : 8'd0;
            fault_r    <= fault_r | set_fault_s;
            count_r    <= count_r + {{(CNT_W-1){1'b0}}, retire_s};
        end
    end

    // Next-state and Moore strobe decode; "retire" is the END point of an instruction.
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        set_fault_s  = 1'b0;
        rin = 16'd0;  rout = 16'd0;  alu_ctrl = 5'd0;
        pc_out = 1'b0;  pc_in = 1'b0;  inc_pc = 1'b0;  mar_in = 1'b0;
        mdr_in = 1'b0;  mdr_out = 1'b0;  read = 1'b0;  ir_in = 1'b0;
        y_in = 1'b0;  z_in = 1'b0;  hi_in = 1'b0;  lo_in = 1'b0;
        zlow_out = 1'b0;  zhigh_out = 1'b0;  halted = 1'b0;
        case (state_r)
            ST_IDLE: next_state_s = run ? ST_T0 : ST_IDLE;
            ST_T0: begin
                pc_out = 1'b1;  mar_in = 1'b1;  inc_pc = 1'b1;  z_in = 1'b1;
                next_state_s = ST_T1;
            end
            ST_T1: begin
                zlow_out = 1'b1;  pc_in = 1'b1;  read = 1'b1;  mdr_in = 1'b1;
                if (mem_ready) begin
                    next_state_s = ST_T2;
                end else if (wait_cnt_r >= TIMEOUT_LAST) begin
                    set_fault_s  = 1'b1;
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_T1;
                end
            end
            ST_T2: begin
                mdr_out = 1'b1;  ir_in = 1'b1;
                next_state_s = ST_T3;
            end
            ST_T3: begin
                case (op_class_s)
                    CLS_ALU3:   begin rout = rb_oh_s; y_in = 1'b1; next_state_s = ST_T4; end
                    CLS_UNARY:  begin rout = rb_oh_s; alu_ctrl = alu_op_s; z_in = 1'b1; next_state_s = ST_T4; end
                    CLS_MULDIV: begin rout = ra_oh_s; y_in = 1'b1; next_state_s = ST_T4; end
                    CLS_NOP:    retire_s = 1'b1;
                    CLS_HALT:   next_state_s = ST_HALT;
                    default:    begin set_fault_s = 1'b1; next_state_s = ST_HALT; end
                endcase
            end
            ST_T4: begin
                case (op_class_s)
                    CLS_ALU3:   begin rout = rc_oh_s; alu_ctrl = alu_op_s; z_in = 1'b1; next_state_s = ST_T5; end
                    CLS_UNARY:  begin zlow_out = 1'b1; rin = ra_oh_s; retire_s = 1'b1; end
                    CLS_MULDIV: begin rout = rb_oh_s; alu_ctrl = alu_op_s; z_in = 1'b1; next_state_s = ST_T5; end
                    default:    begin set_fault_s = 1'b1; next_state_s = ST_HALT; end
                endcase
            end
            ST_T5: begin
                case (op_class_s)
                    CLS_ALU3:   begin zlow_out = 1'b1; rin = ra_oh_s; retire_s = 1'b1; end
                    CLS_MULDIV: begin zlow_out = 1'b1; lo_in = 1'b1; next_state_s = ST_T6; end
                    default:    begin set_fault_s = 1'b1; next_state_s = ST_HALT; end
                endcase
            end
            ST_T6: begin
                if (op_class_s == CLS_MULDIV) begin
                    zhigh_out = 1'b1;  hi_in = 1'b1;  retire_s = 1'b1;
                end else begin
                    set_fault_s  = 1'b1;
                    next_state_s = ST_HALT;
                end
            end
            ST_HALT: begin
                halted       = 1'b1;
                next_state_s = ST_HALT;
            end
            default: next_state_s = ST_IDLE;
        endcase
        // Run is only consulted at the END of an instruction.
        if (retire_s) begin
            next_state_s = run ? ST_T0 : ST_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: fetch, ALU/unary/MUL sequences,
// read-wait timeout boundary, illegal and HALT opcodes, and clear recovery.
module tb_control_sequencer;

    logic        clock, clear, run, mem_ready;
    logic [31:0] ir;
    logic [15:0] rin, rout;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in;
    logic y_in, z_in, hi_in, lo_in, zlow_out, zhigh_out, halted, fault;
    logic [4:0]  alu_ctrl;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    localparam logic [13:0] SB_PCOUT = 14'h2000, SB_PCIN  = 14'h1000, SB_INCPC = 14'h0800;
    localparam logic [13:0] SB_MARIN = 14'h0400, SB_MDRIN = 14'h0200, SB_MDROUT = 14'h0100;
    localparam logic [13:0] SB_READ  = 14'h0080, SB_IRIN  = 14'h0040, SB_YIN   = 14'h0020;
    localparam logic [13:0] SB_ZIN   = 14'h0010, SB_HIIN  = 14'h0008, SB_LOIN  = 14'h0004;
    localparam logic [13:0] SB_ZLOW  = 14'h0002, SB_ZHIGH = 14'h0001, SB_NONE  = 14'h0000;

    localparam logic [13:0] SB_T0 = SB_PCOUT | SB_MARIN | SB_INCPC | SB_ZIN;
    localparam logic [13:0] SB_T1 = SB_ZLOW | SB_PCIN | SB_READ | SB_MDRIN;
    localparam logic [13:0] SB_T2 = SB_MDROUT | SB_IRIN;

    localparam logic [31:0] IR_ADD  = 32'h19A20000;
    localparam logic [31:0] IR_NEG  = 32'h8A380000;
    localparam logic [31:0] IR_MUL  = {5'b01111, 4'd1, 4'd2, 19'd0};
    localparam logic [31:0] IR_ILL  = {5'b11111, 27'd0};
    localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};

    logic [13:0] strobes;
    logic [56:0] obs;
    assign strobes = {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in,
                      y_in, z_in, hi_in, lo_in, zlow_out, zhigh_out};
    // Observed vector: state, rin, rout, alu_ctrl, strobes, halted, fault
    assign obs = {state_dbg, rin, rout, alu_ctrl, strobes, halted, fault};

    control_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .rin(rin), .rout(rout), .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .zlow_out(zlow_out),
        .zhigh_out(zhigh_out), .alu_ctrl(alu_ctrl), .halted(halted), .fault(fault),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [56:0] ev(input logic [3:0] st, input logic [15:0] ri,
                                       input logic [15:0] ro, input logic [4:0] al,
                                       input logic [13:0] sb, input logic h, input logic f);
        ev = {st, ri, ro, al, sb, h, f};
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'd0;
        tick(); tick();
        checks++;
        if (obs !== ev(4'd0, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b0, 1'b0)) begin
            failures++; $display("FAIL reset_outputs: got %h expected %h", obs, ev(4'd0, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b0, 1'b0));
        end
        checks++;
        if (instr_count !== 32'd0) begin
            failures++; $display("FAIL reset_count: got %0d expected 0", instr_count);
        end
    endtask

    task automatic test_fetch();
        clear = 1'b0; run = 1'b1; ir = IR_ADD;
        tick();
        checks++;
        if (obs !== ev(4'd1, 16'd0, 16'd0, 5'd0, SB_T0, 1'b0, 1'b0)) begin
            failures++; $display("FAIL fetch_t0: got %h expected %h", obs, ev(4'd1, 16'd0, 16'd0, 5'd0, SB_T0, 1'b0, 1'b0));
        end
        tick();
        checks++;
        if (obs !== ev(4'd2, 16'd0, 16'd0, 5'd0, SB_T1, 1'b0, 1'b0)) begin
            failures++; $display("FAIL fetch_t1: got %h expected %h", obs, ev(4'd2, 16'd0, 16'd0, 5'd0, SB_T1, 1'b0, 1'b0));
        end
        tick();
        checks++;
        if (obs !== ev(4'd3, 16'd0, 16'd0, 5'd0, SB_T2, 1'b0, 1'b0)) begin
            failures++; $display("FAIL fetch_t2: got %h expected %h", obs, ev(4'd3, 16'd0, 16'd0, 5'd0, SB_T2, 1'b0, 1'b0));
        end
    endtask

    task automatic test_add();
        run = 1'b0;
        tick();
        checks++;
        if (obs !== ev(4'd4, 16'd0, 16'h0010, 5'd0, SB_YIN, 1'b0, 1'b0)) begin
            failures++; $display("FAIL add_t3: got %h expected %h", obs, ev(4'd4, 16'd0, 16'h0010, 5'd0, SB_YIN, 1'b0, 1'b0));
        end
        tick();
        checks++;
        if (obs !== ev(4'd5, 16'd0, 16'h0010, 5'b00011, SB_ZIN, 1'b0, 1'b0)) begin
            failures++; $display("FAIL add_t4: got %h expected %h", obs, ev(4'd5, 16'd0, 16'h0010, 5'b00011, SB_ZIN, 1'b0, 1'b0));
        end
        run = 1'b1;
        tick();
        checks++;
        if (obs !== ev(4'd6, 16'h0008, 16'd0, 5'd0, SB_ZLOW, 1'b0, 1'b0) || instr_count !== 32'd0) begin
            failures++; $display("FAIL add_t5: got %h cnt %0d expected %h cnt 0", obs, instr_count, ev(4'd6, 16'h0008, 16'd0, 5'd0, SB_ZLOW, 1'b0, 1'b0));
        end
        tick();
        checks++;
        if (state_dbg !== 4'd1 || instr_count !== 32'd1) begin
            failures++; $display("FAIL add_end: got state %0d cnt %0d expected state 1 cnt 1", state_dbg, instr_count);
        end
    endtask

    task automatic test_neg();
        tick(); tick();
        ir = IR_NEG;
        tick();
        checks++;
        if (obs !== ev(4'd4, 16'd0, 16'h0080, 5'b10001, SB_ZIN, 1'b0, 1'b0)) begin
            failures++; $display("FAIL neg_t3: got %h expected %h", obs, ev(4'd4, 16'd0, 16'h0080, 5'b10001, SB_ZIN, 1'b0, 1'b0));
        end
        tick();
        checks++;
        if (obs !== ev(4'd5, 16'h0010, 16'd0, 5'd0, SB_ZLOW, 1'b0, 1'b0)) begin
            failures++; $display("FAIL neg_t4: got %h expected %h", obs, ev(4'd5, 16'h0010, 16'd0, 5'd0, SB_ZLOW, 1'b0, 1'b0));
        end
        tick();
        checks++;
        if (state_dbg !== 4'd1 || instr_count !== 32'd2) begin
            failures++; $display("FAIL neg_end: got state %0d cnt %0d expected state 1 cnt 2", state_dbg, instr_count);
        end
    endtask

    task automatic test_mul();
        int n = 0;
        ir = IR_MUL;
        do begin
            tick();
            n++;
            if (state_dbg == 4'd5) begin
                checks++;
                if (obs !== ev(4'd5, 16'd0, 16'h0004, 5'b01111, SB_ZIN, 1'b0, 1'b0)) begin
                    failures++; $display("FAIL mul_t4: got %h expected %h", obs, ev(4'd5, 16'd0, 16'h0004, 5'b01111, SB_ZIN, 1'b0, 1'b0));
                end
            end else if (state_dbg == 4'd6) begin
                checks++;
                if (obs !== ev(4'd6, 16'd0, 16'd0, 5'd0, SB_LOIN | SB_ZLOW, 1'b0, 1'b0)) begin
                    failures++; $display("FAIL mul_t5: got %h expected %h", obs, ev(4'd6, 16'd0, 16'd0, 5'd0, SB_LOIN | SB_ZLOW, 1'b0, 1'b0));
                end
            end else if (state_dbg == 4'd7) begin
                checks++;
                if (obs !== ev(4'd7, 16'd0, 16'd0, 5'd0, SB_HIIN | SB_ZHIGH, 1'b0, 1'b0)) begin
                    failures++; $display("FAIL mul_t6: got %h expected %h", obs, ev(4'd7, 16'd0, 16'd0, 5'd0, SB_HIIN | SB_ZHIGH, 1'b0, 1'b0));
                end
            end
        end while (state_dbg != 4'd1 && n < 20);
        checks++;
        if (n !== 7 || instr_count !== 32'd3) begin
            failures++; $display("FAIL mul_length: got %0d cycles cnt %0d expected 7 cycles cnt 3", n, instr_count);
        end
    endtask

    task automatic test_timeout();
        int n = 1;
        run = 1'b0; mem_ready = 1'b0;
        tick();
        while (state_dbg == 4'd2 && n < 40) begin
            tick();
            if (state_dbg == 4'd2) n++;
        end
        checks++;
        if (n !== 16 || obs !== ev(4'd8, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b1, 1'b1) || instr_count !== 32'd3) begin
            failures++; $display("FAIL timeout: got %0d wait cycles obs %h cnt %0d expected 16 obs %h cnt 3", n, obs, instr_count, ev(4'd8, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b1, 1'b1));
        end
        clear = 1'b1;
        tick();
        checks++;
        if (obs !== ev(4'd0, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b0, 1'b0) || instr_count !== 32'd0) begin
            failures++; $display("FAIL clear_after_timeout: got %h cnt %0d expected all zero", obs, instr_count);
        end
        clear = 1'b0;
    endtask

    task automatic test_late_ready_illegal();
        run = 1'b1; mem_ready = 1'b0;
        tick();
        run = 1'b0;
        tick();
        repeat (15) tick();
        checks++;
        if (state_dbg !== 4'd2 || fault !== 1'b0) begin
            failures++; $display("FAIL wait_cycle16: got state %0d fault %b expected state 2 fault 0", state_dbg, fault);
        end
        mem_ready = 1'b1; ir = IR_ILL;
        tick();
        checks++;
        if (state_dbg !== 4'd3 || fault !== 1'b0) begin
            failures++; $display("FAIL late_ready: got state %0d fault %b expected state 3 fault 0", state_dbg, fault);
        end
        tick(); tick();
        checks++;
        if (obs !== ev(4'd8, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b1, 1'b1) || instr_count !== 32'd0) begin
            failures++; $display("FAIL illegal_op: got %h cnt %0d expected %h cnt 0", obs, instr_count, ev(4'd8, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b1, 1'b1));
        end
        clear = 1'b1;
        tick();
        checks++;
        if (obs !== ev(4'd0, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b0, 1'b0)) begin
            failures++; $display("FAIL clear_after_illegal: got %h expected all zero", obs);
        end
        clear = 1'b0;
    endtask

    task automatic test_halt_op();
        run = 1'b1; mem_ready = 1'b1; ir = IR_HALT;
        repeat (5) tick();
        repeat (3) tick();
        checks++;
        if (obs !== ev(4'd8, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b1, 1'b0) || instr_count !== 32'd0) begin
            failures++; $display("FAIL halt_op: got %h cnt %0d expected %h cnt 0", obs, instr_count, ev(4'd8, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b1, 1'b0));
        end
        clear = 1'b1;
        tick();
        checks++;
        if (obs !== ev(4'd0, 16'd0, 16'd0, 5'd0, SB_NONE, 1'b0, 1'b0)) begin
            failures++; $display("FAIL clear_after_halt: got %h expected all zero", obs);
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_add();
        test_neg();
        test_mul();
        test_timeout();
        test_late_ready_illegal();
        test_halt_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
